// File: rtl/add_seq_ctrl_pkg.sv
// add_seq_ctrl_pkg: shared state encoding and sizing helper for the wide add sequencer
package add_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int idx_w(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction
endpackage

// File: rtl/add_seq_ctrl_add.sv
// add_seq_ctrl_add: DW-bit add datapath; opt_sub inverts b and forces the +1
module add_seq_ctrl_add #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          opt_sub,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {DW{opt_sub}}} + (DW + 1)'(cin | opt_sub);
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: word-serial NW*DW-bit add/subtract with carry register and result flags
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int NW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NW*DW-1:0] in_a,
  input  logic [NW*DW-1:0] in_b,
  input  logic           in_sub,
  input  logic           in_cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NW*DW-1:0] out_sum,
  output logic           out_cout,
  output logic           out_zero,
  output logic           out_neg,
  output logic           out_ovf
);
  localparam int IW = idx_w(NW);
  state_t state, state_nxt;
  logic [NW*DW-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic sub_q, carry, acc_or, last, co;
  logic [DW-1:0] a_w, b_w, s_w;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = idx == IW'(NW - 1);
  assign a_w = a_q[int'(idx)*DW +: DW];
  assign b_w = b_q[int'(idx)*DW +: DW] ^ {DW{sub_q}};
  add_seq_ctrl_add #(.DW(DW)) u_add (
    .a(a_w),
    .b(b_w),
    .opt_sub(1'b0),
    .cin(carry),
    .sum(s_w),
    .cout(co)
  );
  // next state: accept in IDLE, step words in RUN, hold result in DONE until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // operand capture, per-word sum/carry update and flag registration on the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      acc_or <= 1'b0;
      idx <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_zero <= 1'b0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
        sub_q <= in_sub;
        carry <= in_cin ^ in_sub;
        acc_or <= 1'b0;
        idx <= '0;
      end
      if (state == RUN) begin
        out_sum[int'(idx)*DW +: DW] <= s_w;
        carry <= co;
        acc_or <= acc_or | (|s_w);
        idx <= idx + 1'b1;
        if (last) begin
          out_cout <= co;
          out_zero <= !(acc_or | (|s_w));
          out_neg <= s_w[DW-1];
          out_ovf <= (a_w[DW-1] == b_w[DW-1]) && (s_w[DW-1] != a_w[DW-1]);
        end
      end
    end
  end
endmodule
